// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared constants, state type and sizing helpers for the serializer
//
// Purpose: common definitions imported by the serializer interface, core and top.
// Contents:
//   WIDTH_DEFAULT  default parallel word width
//   state_t        serializer FSM states (IDLE, SHIFT)
//   clog2()        ceiling log2 of a positive integer
//   cnt_width()    bit counter width, never less than one bit
package serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A WIDTH of 1 still needs a one-bit counter to keep vector declarations legal.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/byte_serializer8_if.sv
// rtl/byte_serializer8_if.sv - parallel-in / serial-out handshake bundle
//
// Purpose: groups the word input stream, the serial output stream and busy.
// Signals:
//   din, din_valid, din_ready         parallel word handshake (into the serializer)
//   sout, sout_valid, sout_last       serial bit stream (out of the serializer)
//   sout_ready                        downstream accept for the serial stream
//   busy                              serializer is shifting or holding a buffered word
// Modports:
//   master  the environment side: drives words and sout_ready
//   slave   the serializer side
interface byte_serializer8_if
  import serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             sout_ready;
  logic             busy;

  modport master (
    output din, din_valid, sout_ready,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid, sout_ready,
    output din_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_shift_core.sv
// rtl/piso_shift_core.sv - shift register and bit counter for one serialized word
//
// Purpose: holds the word being emitted and counts how many bits have left.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         capture load_data and restart the count (wins over advance)
//   load_data    next word to emit
//   advance      current bit was taken; shift toward the output end
//   bit_out      bit currently presented at the output end
//   last         the presented bit is the final bit of the word
module piso_shift_core
  import serializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             advance,
  output logic             bit_out,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (advance) begin
      // Zeros fill in behind, so a fully drained register reads as 0.
      if (LSB_FIRST) sreg <= sreg >> 1;
      else           sreg <= sreg << 1;
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_out = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
  assign last    = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/byte_serializer8.sv
// rtl/byte_serializer8.sv - word-to-bit serializer with a one-word skid buffer
//
// Purpose: accepts parallel words and emits them one bit per transfer, flagging
// the final bit of each word; a one-word buffer keeps back-to-back words gapless.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    byte_serializer8_if.slave: din/din_valid/din_ready in,
//          sout/sout_valid/sout_last/sout_ready out, busy
module byte_serializer8
  import serializer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  byte_serializer8_if.slave     bus
);

  state_t           state;
  state_t           next_state;
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             buf_load;
  logic             buf_clear;

  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic             core_load;
  logic [WIDTH-1:0] core_data;
  logic             core_bit;
  logic             core_last;

  // din_ready depends only on registered state (and reset), never on sout_ready.
  assign bus.din_ready = rst_n && ((state == IDLE) || !buf_full);

  assign accept    = bus.din_valid && bus.din_ready;
  assign xfer      = bus.sout_valid && bus.sout_ready;
  assign last_xfer = xfer && core_last;

  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_data  = bus.din;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          core_load  = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (last_xfer) begin
          // Buffered word goes first; din_ready was low, so nothing else arrives.
          if (buf_full) begin
            core_load = 1'b1;
            core_data = buf_data;
            buf_clear = 1'b1;
          end else if (accept) begin
            core_load = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else if (accept) begin
          buf_load = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      state <= next_state;
      if (buf_load) begin
        buf_full <= 1'b1;
        buf_data <= bus.din;
      end else if (buf_clear) begin
        buf_full <= 1'b0;
      end
    end
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load),
    .load_data (core_data),
    .advance   (xfer),
    .bit_out   (core_bit),
    .last      (core_last)
  );

  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = bus.sout_valid && core_bit;
  assign bus.sout_last  = bus.sout_valid && core_last;
  assign bus.busy       = (state == SHIFT) || buf_full;

endmodule

// File: tb/tb_byte_serializer8.sv
// tb/tb_byte_serializer8.sv - directed self-checking bench for byte_serializer8
module tb_byte_serializer8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  byte_serializer8_if #(.WIDTH(8)) bus0 ();
  byte_serializer8_if #(.WIDTH(8)) bus1 ();

  byte_serializer8 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  byte_serializer8 #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus0.din       = 8'hFF;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL reset_sout_valid got=%b exp=0", bus0.sout_valid); end
    checks++; if (bus0.sout !== 1'b0) begin failures++; $display("FAIL reset_sout got=%b exp=0", bus0.sout); end
    checks++; if (bus0.sout_last !== 1'b0) begin failures++; $display("FAIL reset_sout_last got=%b exp=0", bus0.sout_last); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
    checks++; if (bus0.din_ready !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", bus0.din_ready); end
    bus0.din_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (bus0.din_ready !== 1'b1) begin failures++; $display("FAIL post_reset_din_ready got=%b exp=1", bus0.din_ready); end
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL post_reset_sout_valid got=%b exp=0", bus0.sout_valid); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    bus0.din = w;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus0.sout_valid !== 1'b1) begin failures++; $display("FAIL single_valid%0d got=%b exp=1", i, bus0.sout_valid); end
      checks++; if (bus0.sout !== w[7-i]) begin failures++; $display("FAIL single_bit%0d got=%b exp=%b", i, bus0.sout, w[7-i]); end
      checks++; if (bus0.sout_last !== (i == 7)) begin failures++; $display("FAIL single_last%0d got=%b exp=%b", i, bus0.sout_last, (i == 7)); end
      tick();
    end
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", bus0.sout_valid); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", bus0.busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic        exp_rdy;
    w = 16'h3CC3;
    bus0.din = 8'h3C;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    bus0.din = 8'hC3;
    for (int k = 0; k < 16; k++) begin
      exp_rdy = !(k >= 1 && k <= 7);
      checks++; if (bus0.sout_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got=%b exp=1", k, bus0.sout_valid); end
      checks++; if (bus0.sout !== w[15-k]) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", k, bus0.sout, w[15-k]); end
      checks++; if (bus0.sout_last !== (k == 7 || k == 15)) begin failures++; $display("FAIL b2b_last%0d got=%b exp=%b", k, bus0.sout_last, (k == 7 || k == 15)); end
      checks++; if (bus0.din_ready !== exp_rdy) begin failures++; $display("FAIL b2b_din_ready%0d got=%b exp=%b", k, bus0.din_ready, exp_rdy); end
      tick();
      if (k == 0) bus0.din_valid = 1'b0;
    end
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", bus0.sout_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int         idx;
    w = 8'hF0;
    idx = 0;
    bus0.din = w;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      bus0.sout_ready = !(c >= 2 && c <= 4);
      checks++; if (bus0.sout_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", c, bus0.sout_valid); end
      checks++; if (bus0.sout !== w[7-idx]) begin failures++; $display("FAIL bp_bit%0d got=%b exp=%b", c, bus0.sout, w[7-idx]); end
      checks++; if (bus0.sout_last !== (idx == 7)) begin failures++; $display("FAIL bp_last%0d got=%b exp=%b", c, bus0.sout_last, (idx == 7)); end
      tick();
      if (bus0.sout_ready) idx++;
    end
    bus0.sout_ready = 1'b1;
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%b exp=0", bus0.sout_valid); end
  endtask

  task automatic test_buffer_full();
    logic [23:0] w;
    logic        exp_rdy;
    w = 24'h0F9955;
    bus0.din = 8'h0F;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    bus0.din = 8'h99;
    for (int k = 0; k < 24; k++) begin
      exp_rdy = !((k >= 1 && k <= 7) || (k >= 9 && k <= 15));
      checks++; if (bus0.sout_valid !== 1'b1) begin failures++; $display("FAIL buf_valid%0d got=%b exp=1", k, bus0.sout_valid); end
      checks++; if (bus0.sout !== w[23-k]) begin failures++; $display("FAIL buf_bit%0d got=%b exp=%b", k, bus0.sout, w[23-k]); end
      checks++; if (bus0.sout_last !== (k % 8 == 7)) begin failures++; $display("FAIL buf_last%0d got=%b exp=%b", k, bus0.sout_last, (k % 8 == 7)); end
      checks++; if (bus0.din_ready !== exp_rdy) begin failures++; $display("FAIL buf_din_ready%0d got=%b exp=%b", k, bus0.din_ready, exp_rdy); end
      checks++; if (bus0.busy !== 1'b1) begin failures++; $display("FAIL buf_busy%0d got=%b exp=1", k, bus0.busy); end
      tick();
      if (k == 0) bus0.din = 8'h55;
      if (k == 8) bus0.din_valid = 1'b0;
    end
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL buf_end_valid got=%b exp=0", bus0.sout_valid); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL buf_end_busy got=%b exp=0", bus0.busy); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h01;
    bus1.din = w;
    bus1.din_valid = 1'b1;
    bus1.sout_ready = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus1.sout_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid%0d got=%b exp=1", i, bus1.sout_valid); end
      checks++; if (bus1.sout !== w[i]) begin failures++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, bus1.sout, w[i]); end
      checks++; if (bus1.sout_last !== (i == 7)) begin failures++; $display("FAIL lsb_last%0d got=%b exp=%b", i, bus1.sout_last, (i == 7)); end
      tick();
    end
    checks++; if (bus1.sout_valid !== 1'b0) begin failures++; $display("FAIL lsb_end_valid got=%b exp=0", bus1.sout_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'hAA;
    bus0.din = w;
    bus0.din_valid = 1'b1;
    bus0.sout_ready = 1'b1;
    tick();
    bus0.din = 8'h33;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus0.sout !== w[7-k]) begin failures++; $display("FAIL rmid_bit%0d got=%b exp=%b", k, bus0.sout, w[7-k]); end
      tick();
      if (k == 0) bus0.din_valid = 1'b0;
    end
    checks++; if (bus0.busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", bus0.busy); end
    rst_n = 1'b0;
    bus0.din = 8'h81;
    bus0.din_valid = 1'b1;
    tick();
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL rmid_sout_valid got=%b exp=0", bus0.sout_valid); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus0.busy); end
    checks++; if (bus0.din_ready !== 1'b0) begin failures++; $display("FAIL rmid_din_ready got=%b exp=0", bus0.din_ready); end
    tick();
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL rmid_held_valid got=%b exp=0", bus0.sout_valid); end
    bus0.din_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL rmid_release_valid got=%b exp=0", bus0.sout_valid); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL rmid_release_busy got=%b exp=0", bus0.busy); end
    w = 8'h81;
    bus0.din = w;
    bus0.din_valid = 1'b1;
    tick();
    bus0.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus0.sout_valid !== 1'b1) begin failures++; $display("FAIL rmid_after_valid%0d got=%b exp=1", i, bus0.sout_valid); end
      checks++; if (bus0.sout !== w[7-i]) begin failures++; $display("FAIL rmid_after_bit%0d got=%b exp=%b", i, bus0.sout, w[7-i]); end
      checks++; if (bus0.sout_last !== (i == 7)) begin failures++; $display("FAIL rmid_after_last%0d got=%b exp=%b", i, bus0.sout_last, (i == 7)); end
      tick();
    end
    checks++; if (bus0.sout_valid !== 1'b0) begin failures++; $display("FAIL rmid_end_valid got=%b exp=0", bus0.sout_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus0.din = '0;
    bus0.din_valid = 1'b0;
    bus0.sout_ready = 1'b0;
    bus1.din = '0;
    bus1.din_valid = 1'b0;
    bus1.sout_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_buffer_full();
    test_lsb_first();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
